// File: rtl/mult_ctrl_taint_gen_if.sv
// Bus between the multiplier datapath/consumer (master) and the control FSM (slave).
// Carries the handshake, datapath strobes and the taint of every signal.
interface mult_ctrl_taint_gen_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             start_t;
  logic             sgn;
  logic             sgn_t;
  logic             ack;
  logic             ack_t;
  logic [WIDTH-1:0] multiplierReg;
  logic [WIDTH-1:0] multiplierReg_t;

  logic             mdld;
  logic             mrld;
  logic             rsclear;
  logic             rsload;
  logic             rssub;
  logic             rsshr;
  logic             busy;
  logic             productDone;

  logic             mdld_t;
  logic             mrld_t;
  logic             rsclear_t;
  logic             rsload_t;
  logic             rssub_t;
  logic             rsshr_t;
  logic             busy_t;
  logic             productDone_t;

  modport master (
    output start, start_t, sgn, sgn_t, ack, ack_t, multiplierReg, multiplierReg_t,
    input  mdld, mrld, rsclear, rsload, rssub, rsshr, busy, productDone,
    input  mdld_t, mrld_t, rsclear_t, rsload_t, rssub_t, rsshr_t, busy_t, productDone_t
  );

  modport slave (
    input  start, start_t, sgn, sgn_t, ack, ack_t, multiplierReg, multiplierReg_t,
    output mdld, mrld, rsclear, rsload, rssub, rsshr, busy, productDone,
    output mdld_t, mrld_t, rsclear_t, rsload_t, rssub_t, rsshr_t, busy_t, productDone_t
  );
endinterface

// File: rtl/mult_ctrl_taint_gen.sv
// Shift-add multiplier control FSM (optional two's-complement final subtract, done/ack).
// Define MULT_CTRL_TAINT_EN to build the sticky control-flow taint; otherwise every *_t output is 0.
module mult_ctrl_taint_gen #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_ctrl_taint_gen_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [6:0] {
    S_IDLE  = 7'b000_0001,
    S_INIT  = 7'b000_0010,
    S_TEST  = 7'b000_0100,
    S_ADD   = 7'b000_1000,
    S_SUB   = 7'b001_0000,
    S_SHIFT = 7'b010_0000,
    S_DONE  = 7'b100_0000
  } state_e;

  state_e        state_r;
  state_e        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          sgn_q_r;
  logic          sgn_q_s;
  logic [7:0]    strb_r;
  logic          mr_bit_s;
  logic          cnt_last_s;
  logic          taint_s;

  assign mr_bit_s   = bus.multiplierReg[cnt_r];
  assign cnt_last_s = (cnt_r == CNT_LAST);

  // Strobe vector {mdld, mrld, rsclear, rsload, rssub, rsshr, busy, productDone} of a state.
  function automatic logic [7:0] decode(input state_e st);
    logic [7:0] v;
    v = 8'h00;
    case (st)
      S_INIT:  v = 8'b1110_0010;
      S_TEST:  v = 8'b0000_0010;
      S_ADD:   v = 8'b0001_0010;
      S_SUB:   v = 8'b0001_1010;
      S_SHIFT: v = 8'b0000_0110;
      S_DONE:  v = 8'b0000_0001;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Next-state, counter and sign-latch logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    sgn_q_s = sgn_q_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_s = S_INIT;
          sgn_q_s = bus.sgn;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_INIT: begin
        cnt_s   = {CW{1'b0}};
        state_s = S_TEST;
      end
      S_TEST: begin
        if (!mr_bit_s) begin
          state_s = S_SHIFT;
        end else if (sgn_q_r && cnt_last_s) begin
          state_s = S_SUB;
        end else begin
          state_s = S_ADD;
        end
      end
      S_ADD:   state_s = S_SHIFT;
      S_SUB:   state_s = S_SHIFT;
      S_SHIFT: begin
        if (cnt_last_s) begin
          state_s = S_DONE;
        end else begin
          cnt_s   = cnt_r + CW'(1);
          state_s = S_TEST;
        end
      end
      S_DONE: begin
        // A start arriving together with ack is intentionally dropped here.
        if (bus.ack) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, counter, sign latch and strobe registers; strobes track the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
      sgn_q_r <= 1'b0;
      strb_r  <= 8'h00;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      sgn_q_r <= sgn_q_s;
      strb_r  <= decode(state_s);
    end
  end

`ifdef MULT_CTRL_TAINT_EN
  logic st_t_r;
  logic st_t_s;
  logic sgn_q_t_r;
  logic sgn_q_t_s;

  // Sticky taint: any tainted input that steers a decision taints every output.
  always_comb begin
    st_t_s    = st_t_r;
    sgn_q_t_s = sgn_q_t_r;
    case (state_r)
      S_IDLE: begin
        st_t_s = st_t_r | bus.start_t;
        if (bus.start) begin
          sgn_q_t_s = bus.sgn_t;
        end else begin
          sgn_q_t_s = sgn_q_t_r;
        end
      end
      S_TEST: begin
        if (cnt_last_s && mr_bit_s) begin
          st_t_s = st_t_r | bus.multiplierReg_t[cnt_r] | sgn_q_t_r;
        end else begin
          st_t_s = st_t_r | bus.multiplierReg_t[cnt_r];
        end
      end
      S_DONE:  st_t_s = st_t_r | bus.ack_t;
      default: st_t_s = st_t_r;
    endcase
  end

  // Taint registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_t_r    <= 1'b0;
      sgn_q_t_r <= 1'b0;
    end else begin
      st_t_r    <= st_t_s;
      sgn_q_t_r <= sgn_q_t_s;
    end
  end

  assign taint_s = st_t_r;
`else
  logic unused_taint_s;
  assign unused_taint_s = ^{bus.start_t, bus.sgn_t, bus.ack_t, bus.multiplierReg_t};
  assign taint_s        = 1'b0;
`endif

  assign bus.mdld        = strb_r[7];
  assign bus.mrld        = strb_r[6];
  assign bus.rsclear     = strb_r[5];
  assign bus.rsload      = strb_r[4];
  assign bus.rssub       = strb_r[3];
  assign bus.rsshr       = strb_r[2];
  assign bus.busy        = strb_r[1];
  assign bus.productDone = strb_r[0];

  assign bus.mdld_t        = taint_s;
  assign bus.mrld_t        = taint_s;
  assign bus.rsclear_t     = taint_s;
  assign bus.rsload_t      = taint_s;
  assign bus.rssub_t       = taint_s;
  assign bus.rsshr_t       = taint_s;
  assign bus.busy_t        = taint_s;
  assign bus.productDone_t = taint_s;
endmodule
